led_request_arbiter: RTL and testbench

- Shares the 6-LED status bank between NUM_REQ independent requesters (fault, comms, mode, heartbeat, ...).
- Each requester asks to show a 6-bit pattern for a number of display ticks. The block grants requesters round-robin, times the display, and drives the LED driver's led_enable / mtne_mode inputs.
- Maintenance override freezes arbitration and forces all LEDs on.

---
 rtl/led_arb_pkg.sv | 29 ++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_request_arbiter.sv | 160 ++++++++++++++++
 tb/tb_led_request_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED request arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} arb_state_e;

  localparam int unsigned LED_W     = 6;
  localparam int unsigned GAP_TICKS = 1;
  localparam int unsigned MAX_REQ   = 8;

  // Round-robin pick: first set request searching upward from ptr+1, wrapping at num.
  // Returns a one-hot vector (all zero when nothing is requested).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0]         ptr,
                                                 input int unsigned        num);
    logic [MAX_REQ-1:0] pick;
    int unsigned        idx;
    pick = '0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      if (i <= num) begin
        idx = (32'(ptr) + i) % num;
        if ((pick == '0) && req[idx[2:0]]) begin
          pick[idx[2:0]] = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Clock-enable tick generator: one-cycle tick every TICK_DIV enabled cycles.
// clear restarts the count at zero; freeze holds the count and suppresses the tick.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 10000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int unsigned     CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = !freeze && (cnt_q == CNT_MAX);

  // Next count: clear wins, freeze holds, otherwise count 0..TICK_DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!freeze) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_request_arbiter.sv
// Round-robin arbiter sharing the 6-LED status bank between NUM_REQ requesters.
// Optional build macro LED_ARB_PREEMPT_EN: requester 0 preempts any other owner in SHOW.
module led_request_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LED_W-1:0]  req_pattern,
  input  logic [NUM_REQ*HOLD_W-1:0] req_hold,
  input  logic                      mtne_req,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [LED_W-1:0]          led_enable,
  output logic                      mtne_mode,
  output logic                      busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [LED_W-1:0]   pattern_q, pattern_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               tick, tick_clear;
  logic [MAX_REQ-1:0] pick;
  logic [PTR_W-1:0]   pick_idx;
  logic [LED_W-1:0]   pick_pattern;
  logic [HOLD_W-1:0]  pick_hold, zero_hold;
  logic               expire, preempt;

  led_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .clear (tick_clear),
    .freeze(mtne_req),
    .tick  (tick)
  );

`ifdef LED_ARB_PREEMPT_EN
  assign preempt = req[0] && (owner_q != '0);
`else
  assign preempt = 1'b0;
`endif

  // Round-robin winner and its request fields; a zero hold is shown for one tick.
  always_comb begin
    pick     = rr_pick(MAX_REQ'(req), 3'(ptr_q), NUM_REQ);
    pick_idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) pick_idx = PTR_W'(i);
    end
    pick_pattern = req_pattern[pick_idx*LED_W +: LED_W];
    pick_hold    = req_hold[pick_idx*HOLD_W +: HOLD_W];
    if (pick_hold == '0) pick_hold = HOLD_W'(1);
    zero_hold = req_hold[HOLD_W-1:0];
    if (zero_hold == '0) zero_hold = HOLD_W'(1);
  end

  // The last tick of a hold (or gap) period; hold_q never goes below zero.
  assign expire = tick && (hold_q <= HOLD_W'(1));

  // Next-state logic; everything freezes while the maintenance override is active.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    done_d     = '0;
    pattern_d  = pattern_q;
    hold_d     = hold_q;
    tick_clear = 1'b0;
    if (!mtne_req) begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_d    = SHOW;
            grant_d    = pick[NUM_REQ-1:0];
            owner_d    = pick_idx;
            ptr_d      = pick_idx;
            pattern_d  = pick_pattern;
            hold_d     = pick_hold;
            tick_clear = 1'b1;
          end
        end
        SHOW: begin
          if (expire) begin
            // Normal expiry takes priority even if the owner drops req this cycle.
            done_d     = grant_q;
            grant_d    = '0;
            state_d    = GAP;
            hold_d     = HOLD_W'(GAP_TICKS);
            tick_clear = 1'b1;
          end else if (preempt) begin
            grant_d    = NUM_REQ'(1);
            owner_d    = '0;
            ptr_d      = '0;
            pattern_d  = req_pattern[LED_W-1:0];
            hold_d     = zero_hold;
            tick_clear = 1'b1;
          end else if (!req[owner_q]) begin
            grant_d    = '0;
            state_d    = GAP;
            hold_d     = HOLD_W'(GAP_TICKS);
            tick_clear = 1'b1;
          end else if (tick) begin
            hold_d = hold_q - 1'b1;
          end
        end
        GAP: begin
          if (expire) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (tick) begin
            hold_d = hold_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= PTR_W'(NUM_REQ - 1);
      owner_q   <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      pattern_q <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      pattern_q <= pattern_d;
      hold_q    <= hold_d;
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign led_enable = (state_q == SHOW) ? pattern_q : '0;
  assign mtne_mode  = mtne_req;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_led_request_arbiter.sv
// Directed bench for led_request_arbiter with TICK_DIV=4, NUM_REQ=4, HOLD_W=4.
module tb_led_request_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = '0;
  logic [23:0] req_pattern = '0;
  logic [15:0] req_hold = '0;
  logic        mtne_req = 1'b0;
  logic [3:0]  grant, done;
  logic [5:0]  led_enable;
  logic        mtne_mode, busy;

  int n_pass = 0;
  int n_total = 0;

  // Requester i pattern lives in bits [6i+5:6i].
  logic [23:0] pats = {6'h3C, 6'h15, 6'h2A, 6'h07};

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic [5:0] exp_led;
  } vec_t;
  vec_t vecs[7];

  led_request_arbiter #(
    .NUM_REQ (4),
    .TICK_DIV(4),
    .HOLD_W  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_pattern(req_pattern),
    .req_hold   (req_hold),
    .mtne_req   (mtne_req),
    .grant      (grant),
    .done       (done),
    .led_enable (led_enable),
    .mtne_mode  (mtne_mode),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    mtne_req = 1'b0;
    req_hold = '0;
    req_pattern = pats;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // Wait for a grant, measure its length and the following GAP, check done and the LEDs.
  task automatic watch_grant(input string name, input logic [3:0] exp_g, input logic [5:0] exp_led,
                             input int exp_len, input logic [3:0] exp_done, input int exp_gap);
    int n, len, gap, led_bad, extra;
    n = 0;
    while (grant == 4'b0000 && n < 50) begin
      step();
      n++;
    end
    check({name, " owner"}, 32'(grant), 32'(exp_g));
    len = 0;
    led_bad = 0;
    while (grant == exp_g && grant != 4'b0000 && len < 50) begin
      if (led_enable !== exp_led) led_bad++;
      step();
      len++;
    end
    check({name, " led"}, led_bad, 0);
    check({name, " len"}, len, exp_len);
    check({name, " done"}, 32'(done), 32'(exp_done));
    gap = 0;
    extra = 0;
    while (busy && grant == 4'b0000 && gap < 50) begin
      if (gap > 0 && done != 4'b0000) extra++;
      if (led_enable != 6'h00) extra++;
      gap++;
      step();
    end
    check({name, " gap"}, gap, exp_gap);
    check({name, " gap quiet"}, extra, 0);
  endtask

  initial begin
    int len, acc, n;

    vecs[0] = '{4'b0001, 4'b0001, 6'h07};
    vecs[1] = '{4'b0010, 4'b0010, 6'h2A};
    vecs[2] = '{4'b0100, 4'b0100, 6'h15};
    vecs[3] = '{4'b1000, 4'b1000, 6'h3C};
    vecs[4] = '{4'b1010, 4'b0010, 6'h2A};
    vecs[5] = '{4'b1100, 4'b0100, 6'h15};
    vecs[6] = '{4'b0000, 4'b0000, 6'h00};

    // Reset state.
    do_reset();
    check("reset grant", 32'(grant), 0);
    check("reset done", 32'(done), 0);
    check("reset led", 32'(led_enable), 0);
    check("reset busy", 32'(busy), 0);
    check("reset mtne", 32'(mtne_mode), 0);

    // First grant from reset: lowest set request wins, one cycle latency.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      req_hold = 16'h1111;
      req = vecs[i].req;
      step();
      check($sformatf("vec%0d grant", i), 32'(grant), 32'(vecs[i].exp_grant));
      check($sformatf("vec%0d led", i), 32'(led_enable), 32'(vecs[i].exp_led));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_grant != 4'b0000));
    end

    // Single request, hold=3: 12 cycles shown, pattern changes ignored.
    do_reset();
    req_hold = 16'h0030;
    req = 4'b0010;
    step();
    check("single grant", 32'(grant), 32'(4'b0010));
    req_pattern = 24'hFFFFFF;
    watch_grant("single", 4'b0010, 6'h2A, 12, 4'b0010, 4);
    req = 4'b0000;
    step();
    check("single idle grant", 32'(grant), 0);
    check("single idle busy", 32'(busy), 0);

    // Round-robin, all requesting, hold=1 each.
    do_reset();
    req_hold = 16'h1111;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      watch_grant($sformatf("rr%0d", k), 4'(1 << (k % 4)), pats[6*(k%4) +: 6], 4,
                  4'(1 << (k % 4)), 4);
    end

    // Abort: owner 2 drops req 5 cycles into a hold=3 display.
    do_reset();
    req_hold = 16'h0300;
    req = 4'b0100;
    step();
    repeat (4) step();
    check("abort pre", 32'(grant), 32'(4'b0100));
    req = 4'b0000;
    step();
    check("abort grant", 32'(grant), 0);
    check("abort done", 32'(done), 0);
    check("abort busy", 32'(busy), 1);
    check("abort led", 32'(led_enable), 0);
    acc = 0;
    repeat (8) begin
      step();
      if (done != 4'b0000) acc++;
    end
    check("abort no done", acc, 0);
    check("abort idle", 32'(busy), 0);

    // Expiry and owner drop in the same cycle count as normal expiry.
    do_reset();
    req_hold = 16'h0010;
    req = 4'b0010;
    step();
    repeat (3) step();
    req = 4'b0000;
    step();
    check("expire+drop done", 32'(done), 32'(4'b0010));
    check("expire+drop grant", 32'(grant), 0);

    // Maintenance freeze for 10 cycles in a hold=2 display.
    do_reset();
    req_hold = 16'h0002;
    req = 4'b0001;
    step();
    len = 1;
    repeat (2) begin
      step();
      len++;
    end
    mtne_req = 1'b1;
    #1;
    check("mtne mode", 32'(mtne_mode), 1);
    acc = 0;
    repeat (10) begin
      step();
      if (grant == 4'b0001) len++;
      if (done != 4'b0000 || led_enable != 6'h07) acc++;
    end
    check("mtne frozen", acc, 0);
    mtne_req = 1'b0;
    #1;
    check("mtne release", 32'(mtne_mode), 0);
    n = 0;
    while (grant == 4'b0001 && n < 50) begin
      step();
      n++;
      if (grant == 4'b0001) len++;
    end
    check("mtne show len", len, 18);
    check("mtne done", 32'(done), 32'(4'b0001));

    // Async reset mid-SHOW, then requester 0 wins first again.
    do_reset();
    req_hold = 16'h3331;
    req = 4'b1111;
    watch_grant("rst0", 4'b0001, 6'h07, 4, 4'b0001, 4);
    n = 0;
    while (grant == 4'b0000 && n < 50) begin
      step();
      n++;
    end
    check("rst owner1", 32'(grant), 32'(4'b0010));
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    check("rst async grant", 32'(grant), 0);
    check("rst async led", 32'(led_enable), 0);
    check("rst async busy", 32'(busy), 0);
    check("rst async done", 32'(done), 0);
    #3;
    reset = 1'b1;
    step();
    check("rst regrant", 32'(grant), 32'(4'b0001));

    // hold=0 is shown as one tick.
    do_reset();
    req_hold = 16'h0000;
    req = 4'b0010;
    watch_grant("hold0", 4'b0010, 6'h2A, 4, 4'b0010, 4);

    // Requester 0 rising during owner 3's display.
    do_reset();
    req_hold = 16'h3001;
    req = 4'b1000;
    step();
    repeat (2) step();
    req = 4'b1001;
    step();
`ifdef LED_ARB_PREEMPT_EN
    check("preempt grant", 32'(grant), 32'(4'b0001));
    check("preempt no done", 32'(done), 0);
    watch_grant("pre0", 4'b0001, 6'h07, 4, 4'b0001, 4);
    watch_grant("pre3", 4'b1000, 6'h3C, 12, 4'b1000, 4);
`else
    check("nopreempt grant", 32'(grant), 32'(4'b1000));
    watch_grant("nopre3", 4'b1000, 6'h3C, 9, 4'b1000, 4);
    watch_grant("nopre0", 4'b0001, 6'h07, 4, 4'b0001, 4);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
